// File: rtl/led_status_ctrl.sv
// Status-LED scheduler: arbitrates the four board LEDs between boot blink,
// the led_wave generator, a UART activity chaser and an error/cause blinker.
module led_status_ctrl #(
  parameter int ACT_HOLD_CYC   = 5_000_000,
  parameter int BLINK_HALF_CYC = 25_000_000,
  parameter int CNT_W          = 28
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_cal_done,
  input  logic       i_rx_pulse,
  input  logic       i_ovf_pulse,
  input  logic       i_ddr_err,
  input  logic       i_err_clr,
  input  logic [3:0] i_wave_led,
  output logic       o_wave_en,
  output logic [3:0] o_led,
  output logic [1:0] o_state
);

  typedef enum logic [1:0] {
    ST_BOOT = 2'b00,
    ST_IDLE = 2'b01,
    ST_ACT  = 2'b10,
    ST_ERR  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] HOLD_RELOAD = CNT_W'(ACT_HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] BLINK_LAST  = CNT_W'(BLINK_HALF_CYC - 1);
  localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] hold_q, hold_d;
  logic [CNT_W-1:0] blink_q, blink_d;
  logic             phase_q, phase_d;
  logic             ovf_flag_q, ovf_flag_d;
  logic             ddr_flag_q, ddr_flag_d;
  logic [3:0]       act_pat_q, act_pat_d;
  logic             wave_en_q, wave_en_d;
  logic [3:0]       led_q, led_d;
  logic             err_in;

  assign err_in = i_ddr_err | i_ovf_pulse;

  always_comb begin
    state_d    = state_q;
    hold_d     = hold_q;
    blink_d    = blink_q;
    phase_d    = phase_q;
    ovf_flag_d = ovf_flag_q;
    ddr_flag_d = ddr_flag_q;
    act_pat_d  = act_pat_q;

    if (state_q != ST_ERR && err_in) begin
      // Error entry starts the blink in the ON phase so the fault is visible at once.
      state_d    = ST_ERR;
      ovf_flag_d = i_ovf_pulse;
      ddr_flag_d = i_ddr_err;
      blink_d    = '0;
      phase_d    = 1'b1;
    end else begin
      case (state_q)
        ST_BOOT: begin
          if (i_cal_done) begin
            state_d = ST_IDLE;
            blink_d = '0;
            phase_d = 1'b0;
          end else if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            phase_d = ~phase_q;
          end else begin
            blink_d = blink_q + CNT_ONE;
          end
        end
        ST_IDLE: begin
          if (!i_cal_done) begin
            state_d = ST_BOOT;
            blink_d = '0;
            phase_d = 1'b0;
          end else if (i_rx_pulse) begin
            state_d   = ST_ACT;
            act_pat_d = 4'b0001;
            hold_d    = HOLD_RELOAD;
          end
        end
        ST_ACT: begin
          // Losing calibration outranks activity; a pulse on the last hold cycle reloads.
          if (!i_cal_done) begin
            state_d = ST_BOOT;
            blink_d = '0;
            phase_d = 1'b0;
          end else if (i_rx_pulse) begin
            act_pat_d = {act_pat_q[2:0], act_pat_q[3]};
            hold_d    = HOLD_RELOAD;
          end else if (hold_q == '0) begin
            state_d = ST_IDLE;
          end else begin
            hold_d = hold_q - CNT_ONE;
          end
        end
        ST_ERR: begin
          ovf_flag_d = ovf_flag_q | i_ovf_pulse;
          ddr_flag_d = ddr_flag_q | i_ddr_err;
          if (i_err_clr && !err_in) begin
            state_d    = i_cal_done ? ST_IDLE : ST_BOOT;
            ovf_flag_d = 1'b0;
            ddr_flag_d = 1'b0;
            blink_d    = '0;
            phase_d    = 1'b0;
          end else if (blink_q == BLINK_LAST) begin
            blink_d = '0;
            phase_d = ~phase_q;
          end else begin
            blink_d = blink_q + CNT_ONE;
          end
        end
        default: state_d = ST_BOOT;
      endcase
    end

    // Outputs follow the state being entered so they update with it.
    wave_en_d = (state_d == ST_IDLE);
    case (state_d)
      ST_BOOT: led_d = {3'b000, phase_d};
      ST_IDLE: led_d = i_wave_led;
      ST_ACT:  led_d = act_pat_d;
      ST_ERR:  led_d = phase_d ? 4'b1111 : {2'b00, ovf_flag_d, ddr_flag_d};
      default: led_d = 4'b0000;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q    <= ST_BOOT;
      hold_q     <= '0;
      blink_q    <= '0;
      phase_q    <= 1'b0;
      ovf_flag_q <= 1'b0;
      ddr_flag_q <= 1'b0;
      act_pat_q  <= 4'b0001;
      wave_en_q  <= 1'b0;
      led_q      <= 4'b0000;
    end else begin
      state_q    <= state_d;
      hold_q     <= hold_d;
      blink_q    <= blink_d;
      phase_q    <= phase_d;
      ovf_flag_q <= ovf_flag_d;
      ddr_flag_q <= ddr_flag_d;
      act_pat_q  <= act_pat_d;
      wave_en_q  <= wave_en_d;
      led_q      <= led_d;
    end
  end

  assign o_state   = state_q;
  assign o_wave_en = wave_en_q;
  assign o_led     = led_q;

endmodule

// File: tb/tb_led_status_ctrl.sv
// Directed plus random bench for led_status_ctrl against a timestamp-based
// reference model (blink phase and activity dwell derived from edge counts).
module tb_led_status_ctrl;

  localparam int ACT_HOLD = 8;
  localparam int BLINK    = 4;

  logic       clk;
  logic       rst_n;
  logic       cal_done, rx, ovf, ddr_err, err_clr;
  logic [3:0] wave;
  logic       o_wave_en;
  logic [3:0] o_led;
  logic [1:0] o_state;

  int total = 0;
  int bad   = 0;

  // reference model: edge index, blink origin, activity bookkeeping
  int   n, t0, p0, last_rx, rx_cnt, m_state;
  bit   m_ovf, m_ddr;
  logic [3:0] exp_led;
  logic [1:0] exp_state;
  logic       exp_en;

  led_status_ctrl #(
    .ACT_HOLD_CYC  (ACT_HOLD),
    .BLINK_HALF_CYC(BLINK),
    .CNT_W         (28)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_cal_done (cal_done),
    .i_rx_pulse (rx),
    .i_ovf_pulse(ovf),
    .i_ddr_err  (ddr_err),
    .i_err_clr  (err_clr),
    .i_wave_led (wave),
    .o_wave_en  (o_wave_en),
    .o_led      (o_led),
    .o_state    (o_state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic bit phase_at(int e);
    return bit'((p0 + ((e - t0) / BLINK)) % 2);
  endfunction

  task automatic model_reset();
    n = 0; t0 = 0; p0 = 0; last_rx = 0; rx_cnt = 0; m_state = 0;
    m_ovf = 0; m_ddr = 0;
    exp_state = 2'b00; exp_led = 4'b0000; exp_en = 1'b0;
  endtask

  task automatic model_edge();
    n++;
    if (m_state != 3 && (ddr_err || ovf)) begin
      m_state = 3; m_ovf = ovf; m_ddr = ddr_err; t0 = n; p0 = 1;
    end else begin
      case (m_state)
        0: if (cal_done) m_state = 1;
        1: begin
          if (!cal_done) begin m_state = 0; t0 = n; p0 = 0; end
          else if (rx) begin m_state = 2; last_rx = n; rx_cnt = 0; end
        end
        2: begin
          if (!cal_done) begin m_state = 0; t0 = n; p0 = 0; end
          else if (rx) begin last_rx = n; rx_cnt++; end
          else if (n - last_rx >= ACT_HOLD) m_state = 1;
        end
        default: begin
          if (ovf) m_ovf = 1;
          if (ddr_err) m_ddr = 1;
          if (err_clr && !ddr_err && !ovf) begin
            m_ovf = 0; m_ddr = 0; t0 = n; p0 = 0;
            m_state = cal_done ? 1 : 0;
          end
        end
      endcase
    end
    exp_state = 2'(m_state);
    exp_en    = (m_state == 1);
    case (m_state)
      0:       exp_led = {3'b000, phase_at(n)};
      1:       exp_led = wave;
      2:       exp_led = 4'(1 << (rx_cnt % 4));
      default: exp_led = phase_at(n) ? 4'b1111 : {2'b00, m_ovf, m_ddr};
    endcase
  endtask

  task automatic check(input string tag);
    total++;
    assert (o_state === exp_state) else begin
      bad++;
      $error("FAIL %s_state n=%0d got=%b exp=%b", tag, n, o_state, exp_state);
    end
    total++;
    assert (o_led === exp_led) else begin
      bad++;
      $error("FAIL %s_led n=%0d got=%b exp=%b", tag, n, o_led, exp_led);
    end
    total++;
    assert (o_wave_en === exp_en) else begin
      bad++;
      $error("FAIL %s_wave_en n=%0d got=%b exp=%b", tag, n, o_wave_en, exp_en);
    end
  endtask

  task automatic step(input string tag);
    @(posedge clk);
    model_edge();
    #1;
    check(tag);
    wave = 4'($urandom_range(0, 15));
  endtask

  task automatic steps(input int k, input string tag);
    for (int i = 0; i < k; i++) step(tag);
  endtask

  initial begin
    rst_n = 1'b0; cal_done = 0; rx = 0; ovf = 0; ddr_err = 0; err_clr = 0;
    wave = 4'b0101;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("reset");
    @(negedge clk);
    rst_n = 1'b1;

    // boot blink with rx pulses ignored
    for (int i = 0; i < 20; i++) begin
      rx = (i % 5 == 2);
      step("boot");
    end
    rx = 0;
    cal_done = 1;
    step("cal_up");
    steps(5, "idle");

    // single activity pulse and full dwell
    rx = 1; step("act_enter"); rx = 0;
    steps(10, "act_dwell");

    // chase pattern, then pulse exactly on the hold==0 cycle
    for (int p = 0; p < 5; p++) begin
      rx = 1; step("chase"); rx = 0;
      if (p < 4) steps(2, "chase_gap");
    end
    steps(7, "hold_run");
    rx = 1; step("hold_zero_pulse"); rx = 0;
    steps(10, "hold_exit");

    // overflow error, ddr error, clear gating
    rx = 1; step("act2"); rx = 0;
    ovf = 1; step("ovf_enter"); ovf = 0;
    steps(10, "err_blink");
    ddr_err = 1; steps(10, "err_ddr");
    err_clr = 1; steps(2, "clr_blocked");
    ddr_err = 0; step("clr_exit");
    err_clr = 0;
    steps(3, "post_clr");

    // clear together with overflow stays; clear without calibration goes to boot
    ovf = 1; step("ovf2"); ovf = 0;
    steps(2, "err2");
    err_clr = 1; ovf = 1; step("clr_ovf_same"); ovf = 0; err_clr = 0;
    steps(3, "err2_hold");
    cal_done = 0; err_clr = 1; step("clr_to_boot"); err_clr = 0;
    steps(6, "boot2");

    // randomized traffic
    cal_done = 1;
    for (int i = 0; i < 800; i++) begin
      cal_done = ($urandom_range(0, 59) != 0);
      rx       = ($urandom_range(0, 3) == 0);
      ovf      = ($urandom_range(0, 79) == 0);
      if ($urandom_range(0, 99) == 0) ddr_err = ~ddr_err;
      err_clr  = ($urandom_range(0, 5) == 0);
      step("rand");
    end
    rx = 0; ovf = 0; ddr_err = 0; err_clr = 1; cal_done = 1;
    steps(2, "rand_drain");
    err_clr = 0;

    // asynchronous reset in the middle of ACT
    rx = 1; step("act3"); rx = 0;
    steps(2, "act3_run");
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    check("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    cal_done = 0;
    steps(6, "after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/led_status_ctrl.md
Name: led_status_ctrl

Overview:
- Status-LED scheduler for the UART→FIFO→DDR board.
- Shares the four board LEDs between three owners: the led_wave pattern generator, a UART activity indicator, and an error/cause blinker.
- Runs a priority FSM (error > activity > idle wave > boot) and drives the led_wave enable.
- Muxes the final LED outputs from the active owner.

Parameters:
ACT_HOLD_CYC, 5_000_000, cycles ACT persists after the last rx pulse (50 ms at 100 MHz), must be ≥1
BLINK_HALF_CYC, 25_000_000, half-period in cycles of the BOOT/ERR blink, must be ≥1
CNT_W, 28, width of the internal hold/blink counters, must hold max(ACT_HOLD_CYC, BLINK_HALF_CYC)

Ports:
i_clk  in  1  system clock, 100 MHz
i_rst_n  in  1  asynchronous active-low reset
i_cal_done  in  1  DDR calibration complete, level
i_rx_pulse  in  1  one-cycle pulse per UART byte received
i_ovf_pulse  in  1  one-cycle pulse on FIFO overflow
i_ddr_err  in  1  DDR error, level
i_err_clr  in  1  error acknowledge, level
i_wave_led  in  4  led_wave outputs {led_4,led_3,led_2,led_1}
o_wave_en  out  1  enable to led_wave; its low state synchronously clears led_wave
o_led  out  4  board LEDs
o_state  out  2  current state: BOOT=00, IDLE=01, ACT=10, ERR=11

Behaviour:
- Reset (async assert, sync release):
  - state=BOOT, o_wave_en=0, o_led=0000.
  - Hold counter, blink counter, blink phase and ovf_flag/ddr_flag all 0.
  - act_pat=0001.
- All outputs are registered.
- Next-state priority, evaluated every cycle:
  1. Error entry: (i_ddr_err | i_ovf_pulse) from any non-ERR state → ERR.
     - Set the matching flag(s).
     - Clear the blink counter; set phase=ON.
  2. Per-state rules:
- BOOT:
  - o_wave_en=0.
  - o_led={3'b000, phase}. Phase toggles every BLINK_HALF_CYC cycles, first toggle to 1 after BLINK_HALF_CYC cycles.
  - i_cal_done=1 → IDLE.
  - i_rx_pulse is ignored.
- IDLE:
  - o_wave_en=1.
  - o_led=i_wave_led, registered (one cycle lag).
  - i_rx_pulse → ACT: act_pat=0001, hold=ACT_HOLD_CYC-1, o_wave_en=0 in the same registered update.
  - i_cal_done=0 → BOOT: blink counter and phase cleared.
- ACT:
  - o_wave_en=0, o_led=act_pat.
  - Each further i_rx_pulse rotates act_pat left (1000 wraps to 0001) and reloads hold=ACT_HOLD_CYC-1.
  - No pulse with hold≠0: hold decrements.
  - No pulse with hold==0 → IDLE. Total dwell after the last pulse is exactly ACT_HOLD_CYC cycles.
  - A pulse arriving in the cycle hold==0 stays in ACT (reload wins).
  - i_cal_done=0 → BOOT; this takes priority over rx.
- ERR:
  - o_wave_en=0.
  - Phase toggles every BLINK_HALF_CYC cycles.
  - o_led = phase ? 1111 : {2'b00, ovf_flag, ddr_flag}.
  - Further i_ovf_pulse sets ovf_flag; i_ddr_err=1 sets ddr_flag. Flags are sticky.
  - Exit only when i_err_clr=1 AND i_ddr_err=0 AND i_ovf_pulse=0 in the same cycle:
    - → IDLE if i_cal_done=1, else → BOOT.
    - Both flags clear; blink counter and phase clear.
  - i_err_clr together with i_ovf_pulse: stay in ERR, ovf_flag set.
- o_wave_en deasserts on every exit from IDLE, so led_wave restarts its wave from counter 0 on each return to IDLE.
- Counters saturate nowhere. Blink counter counts 0..BLINK_HALF_CYC-1 and wraps with a phase toggle.
- Reset asserted mid-operation forces the reset values immediately (async), regardless of state.

Test Plan:
Sim parameters: ACT_HOLD_CYC=8, BLINK_HALF_CYC=4.
- Reset then i_cal_done=0 for 20 cycles → o_state=00, o_led[0] toggles every 4 cycles starting 0 (first 1 at cycle 4), o_led[3:1]=000, o_wave_en=0; raise i_cal_done → next cycle o_state=01, o_wave_en=1, o_led follows i_wave_led one cycle late.
- In IDLE, single i_rx_pulse → o_state=10, o_led=0001, o_wave_en=0; exactly 8 cycles after the pulse cycle o_state=01; rx pulses in BOOT leave o_state=00.
- In ACT, 5 rx pulses 3 cycles apart → o_led 0001,0010,0100,1000,0001; ACT held until 8 cycles after the last pulse; pulse on the hold==0 cycle keeps ACT.
- In ACT, i_ovf_pulse → o_state=11, o_led=1111 for 4 cycles then 0010, alternating; assert i_ddr_err → off-phase shows 0011; i_err_clr with i_ddr_err=1 → stays ERR; drop i_ddr_err with i_err_clr=1 → o_state=01, flags cleared.
- In ERR, i_err_clr and i_ovf_pulse in the same cycle → stays ERR with ovf_flag=1; i_err_clr with i_cal_done=0 → o_state=00.
- Assert i_rst_n=0 asynchronously mid-ACT (between clock edges) → o_led=0000, o_wave_en=0, o_state=00 before the next edge.
